// File: rtl/call_ret_ctrl.sv
// rtl/call_ret_ctrl.sv - CALL/RET sequencer driving an external return-address stack
// Optional build macro: CALL_RET_UNDERFLOW_TRAP_EN (RET at empty depth faults instead of popping)
module call_ret_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             isCall,
  input  logic             isRet,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] stackOut,
  input  logic             stackOverflow,
  output logic             writeStack,
  output logic             readStack,
  output logic [WIDTH-1:0] pcPush,
  output logic [WIDTH-1:0] npc,
  output logic             npcValid,
  output logic             busy,
  output logic             fault
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP,
    WAIT,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [DW-1:0]    depth, depth_n;
  logic             write_stack_n, read_stack_n, npc_valid_n, fault_n;
  logic [WIDTH-1:0] pc_push_n, npc_n;

  // busy decodes straight from the state register, so it is glitch-free and edge-aligned
  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      depth      <= '0;
      writeStack <= 1'b0;
      readStack  <= 1'b0;
      npcValid   <= 1'b0;
      fault      <= 1'b0;
      pcPush     <= '0;
      npc        <= '0;
    end else begin
      state      <= state_n;
      depth      <= depth_n;
      writeStack <= write_stack_n;
      readStack  <= read_stack_n;
      npcValid   <= npc_valid_n;
      fault      <= fault_n;
      pcPush     <= pc_push_n;
      npc        <= npc_n;
    end
  end

  always_comb begin
    state_n       = state;
    depth_n       = depth;
    write_stack_n = 1'b0;
    read_stack_n  = 1'b0;
    npc_valid_n   = 1'b0;
    fault_n       = fault;
    pc_push_n     = pcPush;
    npc_n         = npc;

    unique case (state)
      IDLE: begin
        // CALL has priority; a simultaneous RET is simply dropped
        if (isCall) begin
          if ((depth == DEPTH_MAX) || stackOverflow) begin
            fault_n = 1'b1;
          end else begin
            write_stack_n = 1'b1;
            pc_push_n     = pc + WIDTH'(1);
            npc_n         = target;
            npc_valid_n   = 1'b1;
            depth_n       = depth + DW'(1);
            state_n       = PUSH;
          end
        end else if (isRet) begin
`ifdef CALL_RET_UNDERFLOW_TRAP_EN
          if (depth == '0) begin
            fault_n = 1'b1;
          end else begin
            read_stack_n = 1'b1;
            depth_n      = depth - DW'(1);
            state_n      = POP;
          end
`else
          read_stack_n = 1'b1;
          if (depth != '0) depth_n = depth - DW'(1);
          state_n = POP;
`endif
        end
      end
      PUSH: state_n = IDLE;
      POP:  state_n = WAIT;
      WAIT: begin
        // stack data becomes valid one cycle after the pop strobe
        npc_n       = stackOut;
        npc_valid_n = 1'b1;
        state_n     = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_call_ret_ctrl.sv
// tb/tb_call_ret_ctrl.sv - directed self-checking bench for call_ret_ctrl with a small stack model
module tb_call_ret_ctrl;

  localparam int W = 32;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         isCall = 1'b0;
  logic         isRet = 1'b0;
  logic [W-1:0] pc = '0;
  logic [W-1:0] target = '0;
  logic [W-1:0] stackOut;
  logic         stackOverflow = 1'b0;
  logic         writeStack, readStack, npcValid, busy, fault;
  logic [W-1:0] pcPush, npc;

  int errors = 0;
  int checks = 0;
  int pulses;

  logic [W-1:0] mem [8];
  int           sp;

  call_ret_ctrl #(.DEPTH(D), .WIDTH(W)) dut (
    .clock(clock), .reset(reset), .isCall(isCall), .isRet(isRet),
    .pc(pc), .target(target), .stackOut(stackOut), .stackOverflow(stackOverflow),
    .writeStack(writeStack), .readStack(readStack), .pcPush(pcPush),
    .npc(npc), .npcValid(npcValid), .busy(busy), .fault(fault)
  );

  always #5 clock = ~clock;

  // behavioural return-address stack: data appears the cycle after the pop strobe
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp       <= 0;
      stackOut <= '0;
    end else if (writeStack) begin
      if (sp < 8) begin
        mem[sp] <= pcPush;
        sp      <= sp + 1;
      end
    end else if (readStack) begin
      if (sp > 0) begin
        stackOut <= mem[sp-1];
        sp       <= sp - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ws"}, W'(writeStack), 0);
    chk({tag, "_rs"}, W'(readStack), 0);
    chk({tag, "_nv"}, W'(npcValid), 0);
    chk({tag, "_busy"}, W'(busy), 0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    step();
    #2 reset = 1'b1;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_ws", W'(writeStack), 0);
    chk("rst_rs", W'(readStack), 0);
    chk("rst_nv", W'(npcValid), 0);
    chk("rst_fault", W'(fault), 0);
    chk("rst_pcpush", pcPush, 0);
    chk("rst_npc", npc, 0);
    chk("rst_busy", W'(busy), 0);
    step();
    #2 reset = 1'b1;
    step();

    // CALL pc=100 target=400
    pc = 100; target = 400; isCall = 1'b1;
    step();
    isCall = 1'b0;
    chk("call_ws", W'(writeStack), 1);
    chk("call_pcpush", pcPush, 101);
    chk("call_npc", npc, 400);
    chk("call_nv", W'(npcValid), 1);
    chk("call_busy", W'(busy), 1);
    step();
    chk_idle_zero("call_end");

    // RET returns 101 three edges after isRet is sampled
    isRet = 1'b1;
    step();
    isRet = 1'b0;
    chk("ret_rs", W'(readStack), 1);
    chk("ret_nv0", W'(npcValid), 0);
    step();
    chk("ret_rs_clr", W'(readStack), 0);
    chk("ret_nv1", W'(npcValid), 0);
    step();
    chk("ret_nv", W'(npcValid), 1);
    chk("ret_npc", npc, 101);
    step();
    chk_idle_zero("ret_end");

    // simultaneous CALL+RET: CALL wins; request held during PUSH is ignored
    pc = 20; target = 80; isCall = 1'b1; isRet = 1'b1;
    step();
    isRet = 1'b0;
    chk("sim_ws", W'(writeStack), 1);
    chk("sim_rs", W'(readStack), 0);
    chk("sim_pcpush", pcPush, 21);
    chk("sim_npc", npc, 80);
    step();
    isCall = 1'b0;
    chk("busy_ignore_ws", W'(writeStack), 0);
    chk("busy_ignore_rs", W'(readStack), 0);
    chk("busy_ignore_busy", W'(busy), 0);
    step();
    chk("busy_ignore_ws2", W'(writeStack), 0);

    // drain the one entry
    isRet = 1'b1;
    step();
    isRet = 1'b0;
    step();
    step();
    chk("ret2_nv", W'(npcValid), 1);
    chk("ret2_npc", npc, 21);
    step();

    // underflow: RET at depth 0
    isRet = 1'b1;
    step();
    isRet = 1'b0;
`ifdef CALL_RET_UNDERFLOW_TRAP_EN
    chk("under_rs", W'(readStack), 0);
    chk("under_fault", W'(fault), 1);
    chk("under_busy", W'(busy), 0);
`else
    chk("under_rs", W'(readStack), 1);
    chk("under_fault", W'(fault), 0);
    step();
    step();
    chk("under_nv", W'(npcValid), 1);
    step();
    chk("under_fault2", W'(fault), 0);
`endif
    do_reset();
    chk("rst2_fault", W'(fault), 0);

    // overflow at DEPTH=4: fifth CALL faults with no push
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      pc = W'(i * 10); target = W'(1000 + i); isCall = 1'b1;
      step();
      isCall = 1'b0;
      pulses += int'(writeStack);
      if (i < 4) begin
        chk("ovf_ws", W'(writeStack), 1);
        chk("ovf_fault0", W'(fault), 0);
      end else begin
        chk("ovf_ws5", W'(writeStack), 0);
        chk("ovf_nv5", W'(npcValid), 0);
        chk("ovf_fault", W'(fault), 1);
        chk("ovf_busy", W'(busy), 0);
      end
      step();
    end
    chk("ovf_pulses", W'(pulses), 4);
    step();
    step();
    chk("fault_sticky", W'(fault), 1);

    // stackOverflow flag also blocks a CALL
    do_reset();
    stackOverflow = 1'b1; pc = 5; target = 9; isCall = 1'b1;
    step();
    isCall = 1'b0; stackOverflow = 1'b0;
    chk("sovf_ws", W'(writeStack), 0);
    chk("sovf_nv", W'(npcValid), 0);
    chk("sovf_fault", W'(fault), 1);

    // reset asserted in WAIT aborts the RET
    do_reset();
    pc = 300; target = 700; isCall = 1'b1;
    step();
    isCall = 1'b0;
    step();
    isRet = 1'b1;
    step();
    isRet = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("abort_ws", W'(writeStack), 0);
    chk("abort_rs", W'(readStack), 0);
    chk("abort_nv", W'(npcValid), 0);
    chk("abort_npc", npc, 0);
    chk("abort_pcpush", pcPush, 0);
    chk("abort_busy", W'(busy), 0);
    step();
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_nv", W'(npcValid), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
